// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt pending front-end.
package irq_pkg;

  localparam int N_IRQ           = 8;
  localparam int ID_W            = 3;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational highest-index-wins picker: vector -> {id, any}; id is 0 when nothing is set.
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0] vec,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  always_comb begin
    id = '0;
    // Ascending scan so the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < N_IRQ; i++) begin
      if (vec[i]) id = ID_W'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronise, edge-capture into sticky pending, mask, present id via valid/ack.
// Optional level-sensitive lines are enabled with the IRQ_LEVEL_MODE_EN macro.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
`ifdef IRQ_LEVEL_MODE_EN
  input  logic [N_IRQ-1:0] level_sel,
`endif
  input  logic             req_ack,
  output logic             req_valid,
  output logic [ID_W-1:0]  req_id,
  output logic [N_IRQ-1:0] pending,
  output logic             irq_out
);

  logic [N_IRQ-1:0] sync_lvl;
  logic [N_IRQ-1:0] sync_d_reg;
  logic [N_IRQ-1:0] edge_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] clr_vec;
  logic [N_IRQ-1:0] masked_vec;
  logic             irq_out_reg;
  logic             req_valid_reg, req_valid_next;
  logic [ID_W-1:0]  req_id_reg, req_id_next;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  irq_state_t       state_reg, state_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk) begin
        if (rst) chain_reg <= '0;
        else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], irq_in[gi]};
      end
      assign sync_lvl[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Edge pulse is registered so the pending update is a clean flop-to-flop path.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_d_reg <= '0;
      edge_reg   <= '0;
    end else begin
      sync_d_reg <= sync_lvl;
      edge_reg   <= sync_lvl & ~sync_d_reg;
    end
  end

  assign masked_vec = pending_reg & ~mask;

  irq_prio_pick u_pick (
    .vec (masked_vec),
    .id  (pick_id),
    .any (pick_any)
  );

  always_comb begin
    state_next     = state_reg;
    req_valid_next = req_valid_reg;
    req_id_next    = req_id_reg;
    clr_vec        = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          req_id_next    = pick_id;
          req_valid_next = 1'b1;
          state_next     = PRESENT;
        end
      end
      PRESENT: begin
        // Held stable: neither higher arrivals nor masking retract the request.
        if (req_ack) begin
          clr_vec        = N_IRQ'(1) << req_id_reg;
          req_valid_next = 1'b0;
          state_next     = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
      end
    endcase
  end

  // A fresh edge on a bit being cleared wins, so the bit stays pending.
  always_comb begin
    pending_next = (pending_reg & ~clr_vec) | edge_reg;
`ifdef IRQ_LEVEL_MODE_EN
    pending_next = (level_sel & sync_lvl) | (~level_sel & pending_next);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      req_valid_reg <= 1'b0;
      req_id_reg    <= '0;
      pending_reg   <= '0;
      irq_out_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_valid_reg <= req_valid_next;
      req_id_reg    <= req_id_next;
      pending_reg   <= pending_next;
      irq_out_reg   <= |masked_vec;
    end
  end

  assign req_valid = req_valid_reg;
  assign req_id    = req_id_reg;
  assign pending   = pending_reg;
  assign irq_out   = irq_out_reg;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed self-checking bench for irq_pending_ctrl: latency, priority, hold, mask, set-wins, reset.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] mask;
  logic             req_ack;
  logic             req_valid;
  logic [ID_W-1:0]  req_id;
  logic [N_IRQ-1:0] pending;
  logic             irq_out;
`ifdef IRQ_LEVEL_MODE_EN
  logic [N_IRQ-1:0] level_sel = '0;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask      (mask),
`ifdef IRQ_LEVEL_MODE_EN
    .level_sel (level_sel),
`endif
    .req_ack   (req_ack),
    .req_valid (req_valid),
    .req_id    (req_id),
    .pending   (pending),
    .irq_out   (irq_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask = '0; req_ack = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_valid",   32'(req_valid), 32'h0);
    check("rst_id",      32'(req_id), 32'h0);
    check("rst_irq_out", 32'(irq_out), 32'h0);

    // Single line: pending at k+3, valid at k+4.
    irq_in = 8'h08;
    tick(3);
    check("t1_pend_k2", 32'(pending), 32'h00);
    tick(1);
    check("t1_pend_k3", 32'(pending), 32'h08);
    check("t1_valid_k3", 32'(req_valid), 32'h0);
    tick(1);
    check("t1_valid_k4", 32'(req_valid), 32'h1);
    check("t1_id", 32'(req_id), 32'h3);
    check("t1_irq_out", 32'(irq_out), 32'h1);
    do_ack();
    check("t1_pend_ack", 32'(pending), 32'h00);
    check("t1_valid_ack", 32'(req_valid), 32'h0);
    tick(1);
    check("t1_valid_gap", 32'(req_valid), 32'h0);
    irq_in = 8'h00;
    tick(4);

    // Two lines together: 7 first, then 0 after the gap.
    irq_in = 8'h81;
    tick(5);
    check("t2_pend", 32'(pending), 32'h81);
    check("t2_id7", 32'(req_id), 32'h7);
    do_ack();
    check("t2_pend_ack1", 32'(pending), 32'h01);
    tick(1);
    check("t2_valid_gap", 32'(req_valid), 32'h0);
    tick(1);
    check("t2_valid0", 32'(req_valid), 32'h1);
    check("t2_id0", 32'(req_id), 32'h0);
    do_ack();
    check("t2_pend_ack2", 32'(pending), 32'h00);
    tick(1);
    irq_in = 8'h00;
    tick(4);

    // No preemption while presenting.
    irq_in = 8'h04;
    tick(5);
    check("t3_id2", 32'(req_id), 32'h2);
    irq_in = 8'h44;
    tick(5);
    check("t3_pend", 32'(pending), 32'h44);
    check("t3_hold_id", 32'(req_id), 32'h2);
    check("t3_hold_valid", 32'(req_valid), 32'h1);
    do_ack();
    check("t3_pend_ack", 32'(pending), 32'h40);
    tick(2);
    check("t3_valid6", 32'(req_valid), 32'h1);
    check("t3_id6", 32'(req_id), 32'h6);
    do_ack();
    tick(1);
    irq_in = 8'h00;
    tick(4);

    // Masked line is retained; ack outside PRESENT is ignored.
    mask = 8'h20;
    irq_in = 8'h20;
    tick(1);
    irq_in = 8'h00;
    tick(4);
    check("t4_pend", 32'(pending), 32'h20);
    check("t4_valid", 32'(req_valid), 32'h0);
    check("t4_irq_out", 32'(irq_out), 32'h0);
    do_ack();
    check("t4_stray_ack", 32'(pending), 32'h20);
    mask = 8'h00;
    tick(1);
    check("t4_irq_out_un", 32'(irq_out), 32'h1);
    check("t4_valid_un", 32'(req_valid), 32'h1);
    check("t4_id5", 32'(req_id), 32'h5);
    do_ack();
    check("t4_pend_ack", 32'(pending), 32'h00);
    tick(1);

    // Ack and new edge on line 4 in the same cycle: set wins.
    irq_in = 8'h10;
    tick(5);
    check("t5_id4", 32'(req_id), 32'h4);
    irq_in = 8'h00;
    tick(2);
    irq_in = 8'h10;
    tick(3);
    do_ack();
    check("t5_setwins", 32'(pending), 32'h10);
    check("t5_valid_ack", 32'(req_valid), 32'h0);
    tick(2);
    check("t5_re_valid", 32'(req_valid), 32'h1);
    check("t5_re_id", 32'(req_id), 32'h4);
    do_ack();
    check("t5_pend_clr", 32'(pending), 32'h00);
    tick(1);
    irq_in = 8'h00;
    tick(4);

    // Reset during PRESENT, lines held high across it.
    irq_in = 8'hFF;
    tick(5);
    check("t6_pend_ff", 32'(pending), 32'hFF);
    check("t6_id7", 32'(req_id), 32'h7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_rst_pend", 32'(pending), 32'h00);
    check("t6_rst_valid", 32'(req_valid), 32'h0);
    check("t6_rst_id", 32'(req_id), 32'h0);
    check("t6_rst_irq_out", 32'(irq_out), 32'h0);
    tick(4);
    check("t6_recap", 32'(pending), 32'hFF);
    tick(1);
    check("t6_recap_id", 32'(req_id), 32'h7);
    do_ack();
    check("t6_once_a", 32'(pending), 32'h7F);
    tick(2);
    check("t6_next_id", 32'(req_id), 32'h6);
    do_ack();
    check("t6_once_b", 32'(pending), 32'h3F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
